// File: rtl/line_ring_buffer_pkg.sv
// Shared definitions for the line ring buffer: FSM encoding, default
// geometry and a small helper for rotating bank indices.
package line_ring_buffer_pkg;

  // FILL: banks are being primed, no output. STREAM: every accepted pixel
  // produces one vertical column.
  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_LINE_WIDTH = 960;
  localparam int DEF_NUM_LINES  = 4;

  // (base + off) mod n, for base < n and off < n.
  function automatic int rot_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/line_bank.sv
// Single-port line RAM with chip select and a registered read.
// Read-first: on a write cycle data_out returns the word being replaced,
// which lets the ring buffer read the oldest line while overwriting it.
// When deselected, data_out holds its last value.
module line_bank
  import line_ring_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_LINE_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  cs_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Selected access: optional write, registered read of the old word.
  always_ff @(posedge clk) begin
    if (!cs_n) begin
      if (wr_en) begin
        r_mem[addr] <= data_in;
      end
      data_out <= r_mem[addr];
    end
  end

endmodule

// File: rtl/line_ring_buffer.sv
// Line ring buffer: stores the previous NUM_LINES-1 lines of a raster in
// rotating single-port banks and, once primed, emits for every accepted
// pixel the vertical column (oldest line in the MSB slice, current pixel in
// the LSB slice) one cycle later through a one-entry output stage.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Input side may present data at any time; in_ready is high whenever the
// output stage is empty or being drained. Output holds data, col and eol
// stable while out_valid && !out_ready.
module line_ring_buffer
  import line_ring_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int ADDR_WIDTH = $clog2(LINE_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sof,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LINES*DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]           out_col,
  output logic                            out_eol,
  output logic                            dbg_state
);

  localparam int NB   = NUM_LINES - 1;
  localparam int WP_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LINE_WIDTH - 1);
  localparam logic [WP_W-1:0]       LAST_WP  = WP_W'(NB - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_col;
  logic [WP_W-1:0]       r_wp;
  logic [WP_W-1:0]       r_line_cnt;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_pix;
  logic [WP_W-1:0]       r_rd_wp;
  logic [ADDR_WIDTH-1:0] r_out_col;
  logic                  r_out_eol;

  logic                            w_accept;
  logic                            w_stream_pix;
  logic [ADDR_WIDTH-1:0]           w_col_eff;
  logic [WP_W-1:0]                 w_wp_eff;
  logic [DATA_WIDTH-1:0]           w_bank_q [NB];
  logic [NUM_LINES*DATA_WIDTH-1:0] w_out_data;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  // A start-of-frame pixel is written as column 0 of line 0 regardless of
  // where the counters currently are.
  assign w_col_eff = sof ? '0 : r_col;
  assign w_wp_eff  = sof ? '0 : r_wp;

  // Only a non-sof pixel in STREAM produces a column.
  assign w_stream_pix = w_accept && !sof && (r_state == ST_STREAM);

  // NB banks; the one at the write pointer holds the oldest line and is
  // overwritten by the current one. In STREAM every bank is read at the
  // current column; in FILL only the written bank is selected. On a stall
  // nothing is selected, so bank outputs (and out_data) stay put.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic w_wr;
    logic w_cs_n;

    assign w_wr   = w_accept && (w_wp_eff == WP_W'(b));
    assign w_cs_n = !(w_wr || w_stream_pix);

    line_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (LINE_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk      (clk),
      .cs_n     (w_cs_n),
      .wr_en    (w_wr),
      .addr     (w_col_eff),
      .data_in  (in_data),
      .data_out (w_bank_q[b])
    );
  end

  // FSM and write-side counters: column, bank pointer and fill line count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FILL;
      r_col      <= '0;
      r_wp       <= '0;
      r_line_cnt <= '0;
    end else if (w_accept) begin
      if (sof) begin
        r_state    <= ST_FILL;
        r_line_cnt <= '0;
      end
      if (w_col_eff == LAST_COL) begin
        r_col <= '0;
        r_wp  <= (w_wp_eff == LAST_WP) ? '0 : w_wp_eff + 1'b1;
        if (r_state == ST_FILL && !sof) begin
          if (r_line_cnt == LAST_WP) begin
            r_state <= ST_STREAM;
          end else begin
            r_line_cnt <= r_line_cnt + 1'b1;
          end
        end
      end else begin
        r_col <= w_col_eff + 1'b1;
        if (sof) begin
          r_wp <= '0;
        end
      end
    end
  end

  // One-entry output stage: capture the pixel and the bank rotation it was
  // read under, and drop valid once drained with nothing new behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_pix       <= '0;
      r_rd_wp     <= '0;
      r_out_col   <= '0;
      r_out_eol   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= w_stream_pix;
      if (w_stream_pix) begin
        r_pix     <= in_data;
        r_rd_wp   <= r_wp;
        r_out_col <= r_col;
        r_out_eol <= (r_col == LAST_COL);
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Column assembly: banks from oldest (the one being overwritten) to
  // newest, then the current pixel. Zero whenever the stage is empty.
  always_comb begin
    w_out_data = '0;
    if (r_out_valid) begin
      for (int i = 0; i < NB; i++) begin
        w_out_data[(NUM_LINES-1-i)*DATA_WIDTH +: DATA_WIDTH] =
          w_bank_q[WP_W'(rot_idx(int'(r_rd_wp), i, NB))];
      end
      w_out_data[DATA_WIDTH-1:0] = r_pix;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = w_out_data;
  assign out_col   = r_out_col;
  assign out_eol   = r_out_eol;
  assign dbg_state = (r_state == ST_STREAM);

endmodule

// File: tb/tb_line_ring_buffer.sv
// Bench for line_ring_buffer with 4-pixel lines, 4-line columns, 8-bit
// pixels. A frame-level model stores every accepted pixel by (line, col)
// and predicts the column each streaming pixel must produce.
module tb_line_ring_buffer;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int NL = 4;
  localparam int AW = 2;
  localparam int OW = NL * DW;
  localparam int EW = OW + AW + 1;

  logic          clk;
  logic          rst_n;
  logic          sof;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [AW-1:0] out_col;
  logic          out_eol;
  logic          dbg_state;

  line_ring_buffer #(
    .DATA_WIDTH (DW),
    .LINE_WIDTH (LW),
    .NUM_LINES  (NL),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sof       (sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_eol   (out_eol),
    .dbg_state (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard / model state
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] m_mem [int];
  int            m_line;
  int            m_col;
  bit            expect_new;
  int            ov_count;
  int            n_checks;
  int            n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  // Runs at the negedge: compares the visible output with the scoreboard
  // head, then feeds the pixel about to be accepted into the model.
  task automatic monitor_step(output bit acc);
    logic [EW-1:0] e;
    logic [OW-1:0] col_data;
    acc = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_mem.delete();
      m_line     = 0;
      m_col      = 0;
      expect_new = 1'b0;
      return;
    end
    if (expect_new) begin
      check("latency_out_valid", 32'(out_valid), 32'd1);
      expect_new = 1'b0;
    end
    if (out_valid) begin
      ov_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q[0];
        check("out_data", out_data, e[EW-1 -: OW]);
        check("out_col", 32'(out_col), 32'(e[AW:1]));
        check("out_eol", 32'(out_eol), 32'(e[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      acc = 1'b1;
      if (sof) begin
        m_line = 0;
        m_col  = 0;
        m_mem.delete();
      end
      m_mem[m_line*LW + m_col] = in_data;
      if (m_line >= NL - 1) begin
        col_data = '0;
        for (int k = 0; k < NL; k++) begin
          col_data[(NL-1-k)*DW +: DW] = m_mem[(m_line-(NL-1)+k)*LW + m_col];
        end
        exp_q.push_back({col_data, AW'(m_col), (m_col == LW - 1)});
        expect_new = 1'b1;
      end
      m_col++;
      if (m_col == LW) begin
        m_col = 0;
        m_line++;
      end
    end
  endtask

  // One cycle: sample at negedge, return at posedge + 1.
  task automatic tick(output bit acc);
    @(negedge clk);
    monitor_step(acc);
    @(posedge clk);
    #1;
  endtask

  // Driver: present one pixel until accepted (bounded).
  task automatic send(input logic [DW-1:0] d, input logic s);
    bit acc;
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    sof      = s;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 20) begin
      tick(acc);
      guard++;
    end
    check("pixel_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
    sof      = 1'b0;
  endtask

  task automatic send_lines(input logic [DW-1:0] base, input int first, input int count, input bit first_sof);
    for (int i = first; i < first + count; i++) begin
      send(base + DW'((i / LW) * 16 + (i % LW)), first_sof && (i == first));
    end
  endtask

  initial begin : main
    bit acc;
    int ov0;
    n_checks   = 0;
    n_pass     = 0;
    ov_count   = 0;
    m_line     = 0;
    m_col      = 0;
    expect_new = 1'b0;
    rst_n      = 1'b0;
    sof        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_col", 32'(out_col), 32'd0);
    check("rst_out_eol", 32'(out_eol), 32'd0);
    check("rst_state_fill", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    tick(acc);
    tick(acc);
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Fill: frame 1 lines 0..2, no output expected
    ov0 = ov_count;
    send_lines(8'h00, 0, 11, 1'b1);
    check("fill_state_before_last", 32'(dbg_state), 32'd0);
    send(8'h23, 1'b0);
    check("fill_state_stream", 32'(dbg_state), 32'd1);
    check("fill_no_out_valid", 32'(ov_count - ov0), 32'd0);

    // Stream line 3
    send(8'h30, 1'b0);
    check("l3c0_data", out_data, 32'h00102030);
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    check("l3c2_data", out_data, 32'h02122232);
    check("l3c2_col", 32'(out_col), 32'd2);
    check("l3c2_eol", 32'(out_eol), 32'd0);
    send(8'h33, 1'b0);
    check("l3c3_eol", 32'(out_eol), 32'd1);

    // Line 4 with backpressure after col 1
    send(8'h40, 1'b0);
    send(8'h41, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h42;
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      check("bp_no_accept", 32'(acc), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_data", out_data, 32'h11213141);
      check("bp_hold_col", 32'(out_col), 32'd1);
    end
    out_ready = 1'b1;
    send(8'h42, 1'b0);
    check("bp_resume_data", out_data, 32'h12223242);
    send(8'h43, 1'b0);

    // Wrap: line 5 col 0
    send(8'h50, 1'b0);
    check("wrap_l5c0_data", out_data, 32'h20304050);
    check("wrap_l5c0_col", 32'(out_col), 32'd0);

    // Mid-frame sof at line 5 col 1: new frame with 0x80 offset
    send(8'h80, 1'b1);
    check("sof_out_valid_low", 32'(out_valid), 32'd0);
    check("sof_state_fill", 32'(dbg_state), 32'd0);
    ov0 = ov_count;
    send_lines(8'h80, 1, 11, 1'b0);
    check("sof_no_out_valid", 32'(ov_count - ov0), 32'd0);
    send(8'hB0, 1'b0);
    check("f2_l3c0_data", out_data, 32'h8090A0B0);
    send(8'hB1, 1'b0);

    // Asynchronous reset between edges while streaming
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", out_data, 32'h0);
    check("arst_out_col", 32'(out_col), 32'd0);
    check("arst_out_eol", 32'(out_eol), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    tick(acc);
    tick(acc);
    rst_n = 1'b1;
    check("arst_in_ready", 32'(in_ready), 32'd1);

    // Refill without sof: 12 pixels before any output
    ov0 = ov_count;
    send_lines(8'hC0, 0, 12, 1'b0);
    check("refill_no_out_valid", 32'(ov_count - ov0), 32'd0);
    send(8'hF0, 1'b0);
    check("refill_first_valid", 32'(out_valid), 32'd1);
    check("refill_l3c0_data", out_data, 32'hC0D0E0F0);
    send(8'hF1, 1'b0);
    send(8'hF2, 1'b0);
    send(8'hF3, 1'b0);
    check("refill_l3c3_eol", 32'(out_eol), 32'd1);

    // Drain
    for (int k = 0; k < 3; k++) tick(acc);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
